// File: rtl/sine_voice_scheduler_if.sv
// Control, configuration, LUT and mix signals of the time-multiplexed sine voice scheduler.
// The slave modport is the scheduler's view of these signals; the master modport is the view of the block that drives it.
interface sine_voice_scheduler_if #(
  parameter int unsigned NUM_VOICES  = 4,
  parameter int unsigned PHASE_WIDTH = 32,
  parameter int unsigned MIX_WIDTH   = 8 + $clog2(NUM_VOICES)
);
  logic                          sample_in;
  logic                          cfg_valid_in;
  logic [$clog2(NUM_VOICES)-1:0] cfg_voice_in;
  logic [PHASE_WIDTH-1:0]        cfg_incr_in;
  logic                          cfg_enable_in;
  logic                          cfg_ready_out;
  logic [5:0]                    lut_phase_out;
  logic [7:0]                    lut_amp_in;
  logic [MIX_WIDTH-1:0]          mix_out;
  logic                          mix_valid_out;
  logic                          busy_out;
  logic                          overrun_out;

  modport master (
    output sample_in, cfg_valid_in, cfg_voice_in, cfg_incr_in, cfg_enable_in, lut_amp_in,
    input  cfg_ready_out, lut_phase_out, mix_out, mix_valid_out, busy_out, overrun_out
  );

  modport slave (
    input  sample_in, cfg_valid_in, cfg_voice_in, cfg_incr_in, cfg_enable_in, lut_amp_in,
    output cfg_ready_out, lut_phase_out, mix_out, mix_valid_out, busy_out, overrun_out
  );
endinterface

// File: rtl/sine_voice_scheduler.sv
// Shares one registered 64-entry sine LUT across NUM_VOICES phase accumulators,
// sweeping all voices once per sample strobe and summing their amplitudes.
module sine_voice_scheduler #(
  parameter int unsigned NUM_VOICES  = 4,
  parameter int unsigned PHASE_WIDTH = 32,
  parameter int unsigned MIX_WIDTH   = 8 + $clog2(NUM_VOICES)
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  sine_voice_scheduler_if.slave   bus
);

  localparam int unsigned VW   = $clog2(NUM_VOICES);
  localparam int unsigned LAST = NUM_VOICES - 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                        state;
  state_t                        state_next;
  logic [VW-1:0]                 idx;
  logic [PHASE_WIDTH-1:0]        phase [NUM_VOICES];
  logic [PHASE_WIDTH-1:0]        incr  [NUM_VOICES];
  logic [NUM_VOICES-1:0]         en;
  logic [5:0]                    addr_hold;
  logic [5:0]                    lut_addr;
  logic                          prev_en;
  logic                          cfg_ready;
  logic                          cfg_fire;
  logic                          busy;
  logic [7:0]                    amp_sb;
  logic signed [MIX_WIDTH-1:0]   amp_ext;
  logic signed [MIX_WIDTH-1:0]   contrib;
  logic signed [MIX_WIDTH-1:0]   acc;
  logic signed [MIX_WIDTH-1:0]   mix;
  logic                          mix_valid;
  logic                          overrun;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    cfg_ready  = 1'b0;
    busy       = 1'b1;
    lut_addr   = addr_hold;
    unique case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
        if (bus.sample_in) state_next = ISSUE;
      end
      ISSUE: begin
        lut_addr = phase[idx][PHASE_WIDTH-1 -: 6];
        if (idx == VW'(LAST)) state_next = DRAIN;
      end
      DRAIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign cfg_fire = bus.cfg_valid_in && cfg_ready;

  // Offset-binary LUT word to two's complement: flipping the MSB subtracts 128.
  assign amp_sb  = {~bus.lut_amp_in[7], bus.lut_amp_in[6:0]};
  assign amp_ext = {{(MIX_WIDTH-8){amp_sb[7]}}, amp_sb};
  assign contrib = prev_en ? amp_ext : '0;

  // Config writes only land in IDLE and phase steps only in ISSUE, so the two never collide.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        phase[v] <= '0;
        incr[v]  <= '0;
      end
      en <= '0;
    end else begin
      if (cfg_fire) begin
        incr[bus.cfg_voice_in] <= bus.cfg_incr_in;
        en[bus.cfg_voice_in]   <= bus.cfg_enable_in;
        if (!bus.cfg_enable_in || !en[bus.cfg_voice_in])
          phase[bus.cfg_voice_in] <= '0;
      end
      if (state == ISSUE && en[idx])
        phase[idx] <= phase[idx] + incr[idx];
    end
  end

  // LUT data trails its address by one cycle, so voice k is summed while voice k+1 is issued.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      idx       <= '0;
      addr_hold <= '0;
      prev_en   <= 1'b0;
      acc       <= '0;
      mix       <= '0;
      mix_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      if (bus.sample_in && state != IDLE) overrun <= 1'b1;
      unique case (state)
        IDLE: idx <= '0;
        ISSUE: begin
          idx       <= idx + VW'(1);
          addr_hold <= lut_addr;
          prev_en   <= en[idx];
          acc       <= (idx == '0) ? '0 : acc + contrib;
        end
        DRAIN: begin
          mix       <= acc + contrib;
          mix_valid <= 1'b1;
        end
        default: idx <= '0;
      endcase
    end
  end

  assign bus.cfg_ready_out = cfg_ready;
  assign bus.lut_phase_out = lut_addr;
  assign bus.mix_out       = mix;
  assign bus.mix_valid_out = mix_valid;
  assign bus.busy_out      = busy;
  assign bus.overrun_out   = overrun;

endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Scoreboard bench for sine_voice_scheduler: a reference model predicts LUT addresses,
// mix values and pulse cycles; a negedge monitor compares them against the DUT.
module tb_sine_voice_scheduler;

  localparam int NV = 4;
  localparam int PW = 32;
  localparam int MW = 8 + $clog2(NV);
  localparam int VW = $clog2(NV);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sine_voice_scheduler_if #(.NUM_VOICES(NV), .PHASE_WIDTH(PW), .MIX_WIDTH(MW)) bus ();

  sine_voice_scheduler #(.NUM_VOICES(NV), .PHASE_WIDTH(PW), .MIX_WIDTH(MW)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  int lut_tab [64];
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.lut_amp_in <= 8'(lut_tab[bus.lut_phase_out]);

  // Reference model state
  typedef struct {int cyc; int val;} exp_t;
  exp_t           addr_q [$];
  exp_t           mix_q  [$];
  exp_t           got;
  logic [PW-1:0]  m_phase [NV];
  logic [PW-1:0]  m_incr  [NV];
  bit             m_en    [NV];
  int             busy_until  = -100;
  bit             exp_overrun = 1'b0;
  bit             cfg_pending = 1'b0;
  int             cfg_v;
  logic [PW-1:0]  cfg_inc;
  bit             cfg_e;

  task automatic model_clear();
    for (int v = 0; v < NV; v++) begin
      m_phase[v] = '0;
      m_incr[v]  = '0;
      m_en[v]    = 1'b0;
    end
    addr_q.delete();
    mix_q.delete();
    busy_until  = -100;
    exp_overrun = 1'b0;
    cfg_pending = 1'b0;
  endtask

  task automatic drive_cfg(input int v, input logic [PW-1:0] inc, input bit e);
    cfg_pending       = 1'b1;
    cfg_v             = v;
    cfg_inc           = inc;
    cfg_e             = e;
    bus.cfg_valid_in  = 1'b1;
    bus.cfg_voice_in  = VW'(v);
    bus.cfg_incr_in   = inc;
    bus.cfg_enable_in = e;
  endtask

  // One clock cycle: apply model for what is driven now, then advance to #1 past the next edge.
  task automatic step();
    bit idle;
    int sum;
    int a;
    idle = (cyc > busy_until);
    check("busy", int'(bus.busy_out), int'(!idle));
    if (cfg_pending) begin
      check("cfg_ready", int'(bus.cfg_ready_out), int'(idle));
      if (idle) begin
        m_incr[cfg_v] = cfg_inc;
        if (!cfg_e || !m_en[cfg_v]) m_phase[cfg_v] = '0;
        m_en[cfg_v] = cfg_e;
        cfg_pending = 1'b0;
      end
    end
    if (bus.sample_in) begin
      if (idle) begin
        sum = 0;
        for (int k = 0; k < NV; k++) begin
          a = int'(m_phase[k][PW-1 -: 6]);
          addr_q.push_back('{cyc + 1 + k, a});
          if (m_en[k]) begin
            sum += lut_tab[a] - 128;
            m_phase[k] = m_phase[k] + m_incr[k];
          end
        end
        mix_q.push_back('{cyc + NV + 2, sum});
        busy_until = cyc + NV + 1;
      end else begin
        exp_overrun = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    bus.sample_in = 1'b0;
    if (!cfg_pending) bus.cfg_valid_in = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic sample_sweep();
    bus.sample_in = 1'b1;
    step();
    steps(7);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.sample_in    = 1'b0;
    bus.cfg_valid_in = 1'b0;
    model_clear();
    #1;
    check("rst_mix", int'($signed(bus.mix_out)), 0);
    check("rst_mix_valid", int'(bus.mix_valid_out), 0);
    check("rst_busy", int'(bus.busy_out), 0);
    check("rst_overrun", int'(bus.overrun_out), 0);
    check("rst_lut_phase", int'(bus.lut_phase_out), 0);
    check("rst_cfg_ready", int'(bus.cfg_ready_out), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (addr_q.size() > 0 && addr_q[0].cyc == cyc) begin
        check("lut_addr", int'(bus.lut_phase_out), addr_q[0].val);
        void'(addr_q.pop_front());
      end
      if (mix_q.size() > 0 && mix_q[0].cyc < cyc) begin
        check("mix_pulse_missing", 0, 1);
        void'(mix_q.pop_front());
      end
      if (bus.mix_valid_out) begin
        if (mix_q.size() == 0) begin
          check("mix_pulse_unexpected", 1, 0);
        end else begin
          got = mix_q.pop_front();
          check("mix_pulse_cycle", cyc, got.cyc);
          check("mix_value", int'($signed(bus.mix_out)), got.val);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int t2_exp [4];
  int guard;

  initial begin
    for (int i = 0; i < 64; i++)
      lut_tab[i] = 128 + $rtoi($floor(127.5 * $sin(2.0 * 3.14159265358979 * i / 64.0)));
    t2_exp[0] = 0; t2_exp[1] = 508; t2_exp[2] = 0; t2_exp[3] = -512;

    bus.sample_in     = 1'b0;
    bus.cfg_valid_in  = 1'b0;
    bus.cfg_voice_in  = '0;
    bus.cfg_incr_in   = '0;
    bus.cfg_enable_in = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Single voice, one LUT step per sample: 0, 12, 24
    drive_cfg(0, 32'h0400_0000, 1'b1);
    step();
    for (int s = 0; s < 3; s++) begin
      bus.sample_in = 1'b1;
      step();
      steps(9);
    end
    check("t1_mix_final", int'($signed(bus.mix_out)), 24);

    // Four voices at quarter-turn increments: peak and trough sums
    do_reset();
    for (int v = 0; v < NV; v++) begin
      drive_cfg(v, 32'h4000_0000, 1'b1);
      step();
    end
    for (int s = 0; s < 4; s++) begin
      sample_sweep();
      if (s != 2) check("t2_mix", int'($signed(bus.mix_out)), t2_exp[s]);
    end

    // Enable, disable and re-enable voice 1; same-cycle config plus strobe
    do_reset();
    drive_cfg(0, 32'h0800_0000, 1'b1); step();
    drive_cfg(1, 32'h0400_0000, 1'b1); step();
    sample_sweep();
    sample_sweep();
    drive_cfg(1, 32'h0400_0000, 1'b0); step();
    sample_sweep();
    drive_cfg(1, 32'h0400_0000, 1'b1); step();
    sample_sweep();
    drive_cfg(2, 32'h1000_0000, 1'b1);
    bus.sample_in = 1'b1;
    step();
    steps(7);
    sample_sweep();
    check("t3_overrun", int'(bus.overrun_out), int'(exp_overrun));

    // Overrun: strobes at t and t+3, then t+10
    bus.sample_in = 1'b1; step();
    steps(2);
    bus.sample_in = 1'b1; step();
    steps(6);
    check("t4_overrun_set", int'(bus.overrun_out), 1);
    check("t4_overrun_model", int'(exp_overrun), 1);
    sample_sweep();
    check("t4_overrun_held", int'(bus.overrun_out), 1);

    // Config write while busy is held off until the first IDLE cycle
    do_reset();
    drive_cfg(3, 32'h0400_0000, 1'b1); step();
    sample_sweep();
    sample_sweep();
    bus.sample_in = 1'b1; step();
    drive_cfg(3, 32'h0400_0000, 1'b0);
    guard = 0;
    while (cfg_pending && guard < 20) begin
      step();
      guard++;
    end
    check("t5_cfg_committed", int'(cfg_pending), 0);
    steps(2);
    sample_sweep();
    check("t5_mix_disabled", int'($signed(bus.mix_out)), 0);

    // Reset at t+2 of a sweep
    drive_cfg(0, 32'h4000_0000, 1'b1); step();
    sample_sweep();
    bus.sample_in = 1'b1; step();
    step();
    do_reset();
    steps(8);
    sample_sweep();
    check("t6_mix_after_reset", int'($signed(bus.mix_out)), 0);
    check("t6_overrun", int'(bus.overrun_out), 0);

    steps(10);
    check("queues_empty", addr_q.size() + mix_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sine_voice_scheduler.md
# sine_voice_scheduler

Time-multiplexes one registered 64-entry sine LUT across NUM_VOICES independent tone voices. Each voice has its own phase accumulator and increment. On every audio sample strobe, the block walks through the voices one per cycle, issues each voice's LUT address, and sums the returned amplitudes into one signed mixed sample. It sits between the audio-rate tick generator and the PWM/DAC output stage, and replaces one LUT instance per tone.

## Interface
- NUM_VOICES, 4: number of voices; must be a power of two, 2..16
- PHASE_WIDTH, 32: phase accumulator width; LUT address is phase[PHASE_WIDTH-1 -: 6]
- MIX_WIDTH, 8+$clog2(NUM_VOICES): mixed output width (10 at default)

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous, active-low reset
- sample_in  input  1  one-cycle audio sample strobe
- cfg_valid_in  input  1  configuration write request
- cfg_voice_in  input  $clog2(NUM_VOICES)  voice index for the write
- cfg_incr_in  input  PHASE_WIDTH  phase increment per sample
- cfg_enable_in  input  1  voice enable
- cfg_ready_out  output  1  config write accepted this cycle when high together with cfg_valid_in
- lut_phase_out  output  6  LUT address; LUT returns offset-binary amplitude one cycle later
- lut_amp_in  input  8  registered LUT data (128 = zero, 255 = peak, 0 = trough)
- mix_out  output  MIX_WIDTH  signed two's-complement sum of enabled voices
- mix_valid_out  output  1  one-cycle pulse when mix_out updates
- busy_out  output  1  high while a sample sweep is in progress
- overrun_out  output  1  sticky; set when sample_in arrives while busy

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE → ISSUE on sample_in.
  - ISSUE holds for NUM_VOICES cycles, one voice index per cycle, ascending from 0.
  - ISSUE → DRAIN after the last voice.
  - DRAIN → IDLE after one cycle.
- cfg_ready_out = (state == IDLE). A write commits at the edge where cfg_valid_in && cfg_ready_out.
  - Updates incr[v] and en[v].
  - On the en[v] 0→1 transition, phase[v] is cleared to 0.
  - If en[v] is already 1, phase[v] is kept (phase-continuous retune).
  - Writing en[v] = 0 clears phase[v].
- Config write and sample_in in the same IDLE cycle: the config commits first, and the sweep uses the new values.
- ISSUE for voice k: lut_phase_out = phase[k] top 6 bits, taken before the increment.
  - At the same edge, if en[k]: phase[k] <= phase[k] + incr[k], modulo 2^PHASE_WIDTH. Wrap-around is silent.
- Accumulation, one cycle after each issue:
  - Signed amplitude = {~lut_amp_in[7], lut_amp_in[6:0]}, sign-extended to MIX_WIDTH.
  - Add it to the accumulator if the voice issued in the previous cycle was enabled; disabled voices add 0.
  - The accumulator clears at sweep start.
- The sum cannot overflow. Range per voice is -128..127, so 4 voices give -512..508 in 10 bits.
- sample_in during ISSUE or DRAIN is ignored and sets overrun_out, which only reset clears.
- Reset (asynchronous, mid-sweep included): abort the sweep. Clear all phases, increments, enables and the accumulator. No mix_valid_out pulse is produced.

## Timing
- Reset values:
  - mix_out = 0, mix_valid_out = 0, busy_out = 0, overrun_out = 0, lut_phase_out = 0.
  - cfg_ready_out = 1 (state IDLE).
- sample_in high in IDLE at cycle t:
  - Cycles t+1..t+N: ISSUE, voice k address driven in cycle t+1+k. busy_out = 1.
  - Cycle t+N+1: DRAIN, last amplitude present.
  - mix_out registered at the edge ending t+N+1.
  - mix_valid_out high for cycle t+N+2 only; busy_out low and cfg_ready_out high in that cycle.
- Sample-to-mix latency: NUM_VOICES+2 cycles (6 at default).
- Minimum sample_in spacing without overrun: NUM_VOICES+2 cycles.
- mix_out holds its value between pulses.
- lut_phase_out holds its last value outside ISSUE.

## Test plan
- Voice 0 only, incr 0x0400_0000, enabled; three sample strobes spaced 10 cycles → mix_out 0, 12, 24 (LUT 128, 140, 152). Each mix_valid_out pulse comes 6 cycles after its strobe.
- All four voices at incr 0x4000_0000:
  - Sample 1 → addresses 0,0,0,0, mix 0.
  - Sample 2 → addresses 16 ×4, mix 508.
  - Sample 4 → addresses 48 ×4, mix -512.
- Voice 1 enabled, then disabled between samples → subsequent mix excludes it; re-enable → its address restarts at 0.
- Strobes at t and t+3 → exactly one mix_valid_out pulse at t+6, overrun_out = 1 and held until reset. Next strobe at t+10 processes normally.
- cfg_valid_in while busy → cfg_ready_out = 0 and no register change. Held until IDLE → commits on the first IDLE cycle.
- rst_n_in low at t+2 of a sweep → all outputs go to reset values immediately; no mix_valid_out pulse; after release, voices are disabled and mix = 0.
